// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the window-memory arbiter.
//   MEM_DEPTH    : window memory size in bytes
//   WIN_LEN      : bytes moved by one window read or write
//   WIN_MAX_ADDR : highest legal window base address
//   mem_grant_t  : which requester owns the current access
//   mem_state_t  : arbiter FSM states
package mem_ctrl_pkg;

    localparam int unsigned MEM_DEPTH    = 2048;
    localparam int unsigned WIN_LEN      = 50;
    localparam logic [15:0] WIN_MAX_ADDR = 16'(MEM_DEPTH - WIN_LEN);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LOAD,
        GNT_RD,
        GNT_WR
    } mem_grant_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } mem_state_t;

endpackage

// File: rtl/mem_window_arbiter_if.sv
// Bundle of requester handshakes and the memory control port.
//   pix_*          : pixel loader byte stream (valid/ready)
//   rd_* / wr_*    : window read / write requests with ack and error flag
//   mem_*          : memory control port (en, r_w, insign, abus, indata)
//   frame_done     : loader region wrapped
//   busy           : arbiter is performing an access
// master = requester side, slave = arbiter side.
interface mem_window_arbiter_if;

    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        frame_done;

    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_ack;
    logic        rd_err;

    logic        wr_req;
    logic [15:0] wr_addr;
    logic        wr_ack;
    logic        wr_err;

    logic        mem_en;
    logic        mem_r_w;
    logic        mem_insign;
    logic [15:0] mem_abus;
    logic [7:0]  mem_indata;

    logic        busy;

    modport master (
        output pix_valid, pix_data, rd_req, rd_addr, wr_req, wr_addr,
        input  pix_ready, frame_done, rd_ack, rd_err, wr_ack, wr_err,
        input  mem_en, mem_r_w, mem_insign, mem_abus, mem_indata, busy
    );

    modport slave (
        input  pix_valid, pix_data, rd_req, rd_addr, wr_req, wr_addr,
        output pix_ready, frame_done, rd_ack, rd_err, wr_ack, wr_err,
        output mem_en, mem_r_w, mem_insign, mem_abus, mem_indata, busy
    );

endinterface

// File: rtl/mem_load_ptr.sv
// Pixel-loader write pointer.
//   clk, reset : clock, async active-low reset (pointer returns to LOAD_BASE)
//   advance    : one loader byte is being written this cycle
//   ptr        : address for the next loader byte
//   wrap       : high in the cycle whose advance wraps the pointer to LOAD_BASE
module mem_load_ptr #(
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LOAD_LEN  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] ptr,
    output logic        wrap
);

    localparam logic [15:0] LOAD_FIRST = 16'(LOAD_BASE);
    localparam logic [15:0] LOAD_LAST  = 16'(LOAD_BASE + LOAD_LEN - 1);

    logic [15:0] ptr_q;
    logic [15:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (ptr_q == LOAD_LAST) ? LOAD_FIRST : ptr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= LOAD_FIRST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr  = ptr_q;
    assign wrap = advance && (ptr_q == LOAD_LAST);

endmodule

// File: rtl/mem_window_arbiter.sv
// Sequencer/arbiter in front of the 2048-byte window memory.
//   clk   : clock, rising edge
//   reset : async active-low reset
//   bus   : requester handshakes and memory control port (slave modport)
// Every access is one IDLE cycle (arbitrate and register) followed by one
// ACCESS cycle (drive memory, pulse ack), so mem_en never stays high for
// two cycles and the address is stable whenever mem_en is high.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | memory idle; arbitrate and capture the winner
//   ST_ACCESS | drive memory from captured values, pulse ack/ready
module mem_window_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LOAD_LEN  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    mem_window_arbiter_if.slave bus
);

    mem_state_t  state_q, state_d;
    mem_grant_t  grant_q, grant_d;
    logic [15:0] addr_q, addr_d;
    logic        r_w_q, r_w_d;
    logic        insign_q, insign_d;
    logic [7:0]  indata_q, indata_d;
    logic        err_q, err_d;
    logic        pref_win_q, pref_win_d;  // 1: window class beats loader
    logic        rr_rd_q, rr_rd_d;        // 1: read beats write

    logic [15:0] load_ptr;
    logic        load_wrap;
    logic        busy;
    logic        win_any;

    assign win_any = bus.rd_req || bus.wr_req;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        r_w_d      = r_w_q;
        insign_d   = insign_q;
        indata_d   = indata_q;
        err_d      = err_q;
        pref_win_d = pref_win_q;
        rr_rd_d    = rr_rd_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = GNT_NONE;
                if (bus.pix_valid && (!win_any || !pref_win_q)) begin
                    grant_d = GNT_LOAD;
                end else if (win_any) begin
                    grant_d = (bus.rd_req && (!bus.wr_req || rr_rd_q)) ? GNT_RD : GNT_WR;
                end

                case (grant_d)
                    GNT_LOAD: begin
                        addr_d     = load_ptr;
                        r_w_d      = 1'b0;
                        insign_d   = 1'b1;
                        indata_d   = bus.pix_data;
                        err_d      = 1'b0;
                        pref_win_d = 1'b1;
                    end
                    GNT_RD: begin
                        addr_d     = bus.rd_addr;
                        r_w_d      = 1'b1;
                        insign_d   = 1'b0;
                        err_d      = (bus.rd_addr > WIN_MAX_ADDR);
                        pref_win_d = 1'b0;
                        rr_rd_d    = 1'b0;
                    end
                    GNT_WR: begin
                        addr_d     = bus.wr_addr;
                        r_w_d      = 1'b0;
                        insign_d   = 1'b0;
                        err_d      = (bus.wr_addr > WIN_MAX_ADDR);
                        pref_win_d = 1'b0;
                        rr_rd_d    = 1'b1;
                    end
                    default: ;
                endcase

                if (grant_d != GNT_NONE) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            addr_q     <= '0;
            r_w_q      <= 1'b1;
            insign_q   <= 1'b0;
            indata_q   <= '0;
            err_q      <= 1'b0;
            pref_win_q <= 1'b1;
            rr_rd_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            r_w_q      <= r_w_d;
            insign_q   <= insign_d;
            indata_q   <= indata_d;
            err_q      <= err_d;
            pref_win_q <= pref_win_d;
            rr_rd_q    <= rr_rd_d;
        end
    end

    // Outputs decode straight from flops so an async reset clears them at once.
    assign busy           = (state_q == ST_ACCESS);
    assign bus.busy       = busy;
    assign bus.mem_en     = busy && !err_q;
    assign bus.mem_r_w    = r_w_q;
    assign bus.mem_insign = insign_q;
    assign bus.mem_abus   = addr_q;
    assign bus.mem_indata = indata_q;

    assign bus.pix_ready  = busy && (grant_q == GNT_LOAD);
    assign bus.rd_ack     = busy && (grant_q == GNT_RD);
    assign bus.rd_err     = bus.rd_ack && err_q;
    assign bus.wr_ack     = busy && (grant_q == GNT_WR);
    assign bus.wr_err     = bus.wr_ack && err_q;
    assign bus.frame_done = load_wrap;

    mem_load_ptr #(
        .LOAD_BASE (LOAD_BASE),
        .LOAD_LEN  (LOAD_LEN)
    ) u_load_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (bus.pix_ready),
        .ptr     (load_ptr),
        .wrap    (load_wrap)
    );

endmodule
